// File: rtl/step_sequencer.sv
// Step sequencer (T0..T3) and instruction register feeding control_unit.
// Optional SEQ_SINGLE_STEP_EN adds iStep to gate the run/advance/wrap transitions.
module step_sequencer #(
    parameter int unsigned IR_W  = 9,
    parameter int unsigned CNT_W = 16
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iRun,
    input  logic [15:0]      iDin,
    input  logic             iIr_en,
    input  logic             iClear,
    input  logic             iDone,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic             iStep,
`endif
    output logic [1:0]       oState,
    output logic [IR_W-1:0]  oIr,
    output logic             oBusy,
    output logic [CNT_W-1:0] oInstr_cnt,
    output logic             oFault
);

    typedef enum logic [1:0] {
        T0 = 2'b00,
        T1 = 2'b01,
        T2 = 2'b10,
        T3 = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [IR_W-1:0]  ir_q, ir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;
    logic             step_ok;

`ifdef SEQ_SINGLE_STEP_EN
    assign step_ok = iStep;
`else
    assign step_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;

        // iClear wins over every stepped transition and is never gated by iStep
        if (iClear) begin
            state_d = T0;
        end else if (step_ok) begin
            unique case (state_q)
                T0: if (iRun) state_d = T1;
                T1: state_d = T2;
                T2: state_d = T3;
                T3: begin
                    state_d = T0;
                    fault_d = 1'b1;
                end
                default: state_d = T0;
            endcase
        end

        if (iIr_en)
            ir_d = IR_W'(iDin[15:7]);

        if (iDone && (state_q != T0))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= T0;
            ir_q    <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign oState     = state_q;
    assign oIr        = ir_q;
    assign oInstr_cnt = cnt_q;
    assign oFault     = fault_q;
    assign oBusy      = (state_q != T0);

endmodule

// File: tb/tb_step_sequencer.sv
// Directed self-checking bench for step_sequencer; a second instance with a
// 2-bit counter exercises counter wrap-around.
module tb_step_sequencer;

    logic        iClk = 1'b0;
    logic        iRst, iRun, iIr_en, iClear, iDone, iStep;
    logic [15:0] iDin;
    logic [1:0]  oState, oState_w;
    logic [8:0]  oIr, oIr_w;
    logic        oBusy, oBusy_w, oFault, oFault_w;
    logic [15:0] oInstr_cnt;
    logic [1:0]  oInstr_cnt_w;

    int tests  = 0;
    int failed = 0;

    always #5 iClk = ~iClk;

    step_sequencer #(.IR_W(9), .CNT_W(16)) dut (
        .iClk(iClk), .iRst(iRst), .iRun(iRun), .iDin(iDin), .iIr_en(iIr_en),
        .iClear(iClear), .iDone(iDone),
`ifdef SEQ_SINGLE_STEP_EN
        .iStep(iStep),
`endif
        .oState(oState), .oIr(oIr), .oBusy(oBusy),
        .oInstr_cnt(oInstr_cnt), .oFault(oFault)
    );

    step_sequencer #(.IR_W(9), .CNT_W(2)) dut_w (
        .iClk(iClk), .iRst(iRst), .iRun(iRun), .iDin(iDin), .iIr_en(iIr_en),
        .iClear(iClear), .iDone(iDone),
`ifdef SEQ_SINGLE_STEP_EN
        .iStep(iStep),
`endif
        .oState(oState_w), .oIr(oIr_w), .oBusy(oBusy_w),
        .oInstr_cnt(oInstr_cnt_w), .oFault(oFault_w)
    );

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic idle_inputs();
        iRst = 0; iRun = 0; iIr_en = 0; iClear = 0; iDone = 0; iStep = 1;
        iDin = 16'h0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        iRst = 1;
        tick();
        iRst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        iRst = 1; iRun = 1; iIr_en = 1; iDin = 16'hFFFF;
        tick();
        tick();
        tests++; if (oState !== 2'b00) begin failed++; $display("FAIL reset_state got %b want 00", oState); end
        tests++; if (oIr !== 9'h000) begin failed++; $display("FAIL reset_ir got %h want 000", oIr); end
        tests++; if (oInstr_cnt !== 16'd0) begin failed++; $display("FAIL reset_cnt got %0d want 0", oInstr_cnt); end
        tests++; if (oFault !== 1'b0) begin failed++; $display("FAIL reset_fault got %b want 0", oFault); end
        tests++; if (oBusy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b want 0", oBusy); end
        // reset in mid-instruction
        idle_inputs();
        iRun = 1;
        tick();
        iRun = 0;
        tick();
        tests++; if (oState !== 2'b10) begin failed++; $display("FAIL reset_mid_reach_t2 got %b want 10", oState); end
        iRst = 1;
        tick();
        iRst = 0;
        tests++; if (oState !== 2'b00) begin failed++; $display("FAIL reset_mid_state got %b want 00", oState); end
    endtask

    task automatic test_two_step();
        do_reset();
        iDin = 16'h2080; iRun = 1; iIr_en = 1;
        tick();
        tests++; if (oIr !== 9'h041) begin failed++; $display("FAIL two_step_ir got %h want 041", oIr); end
        tests++; if (oState !== 2'b01) begin failed++; $display("FAIL two_step_t1 got %b want 01", oState); end
        tests++; if (oBusy !== 1'b1) begin failed++; $display("FAIL two_step_busy got %b want 1", oBusy); end
        iRun = 0; iIr_en = 0; iDin = 16'hFFFF; iClear = 1; iDone = 1;
        tick();
        iClear = 0; iDone = 0;
        tests++; if (oState !== 2'b00) begin failed++; $display("FAIL two_step_end got %b want 00", oState); end
        tests++; if (oInstr_cnt !== 16'd1) begin failed++; $display("FAIL two_step_cnt got %0d want 1", oInstr_cnt); end
        tests++; if (oIr !== 9'h041) begin failed++; $display("FAIL two_step_ir_hold got %h want 041", oIr); end
    endtask

    task automatic test_four_step();
        logic [1:0] exp_seq [4];
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b11; exp_seq[3] = 2'b00;
        do_reset();
        iRun = 1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin iClear = 1; iDone = 1; end
            tick();
            iRun = 0;
            tests++;
            if (oState !== exp_seq[i]) begin
                failed++; $display("FAIL four_step_seq[%0d] got %b want %b", i, oState, exp_seq[i]);
            end
        end
        iClear = 0; iDone = 0;
        tests++; if (oInstr_cnt !== 16'd1) begin failed++; $display("FAIL four_step_cnt got %0d want 1", oInstr_cnt); end
        tests++; if (oFault !== 1'b0) begin failed++; $display("FAIL four_step_fault got %b want 0", oFault); end
    endtask

    task automatic test_runaway();
        do_reset();
        iRun = 1;
        tick();
        iRun = 0;
        tick();
        tick();
        tests++; if (oFault !== 1'b0) begin failed++; $display("FAIL runaway_fault_early got %b want 0", oFault); end
        tick();
        tests++; if (oState !== 2'b00) begin failed++; $display("FAIL runaway_state got %b want 00", oState); end
        tests++; if (oFault !== 1'b1) begin failed++; $display("FAIL runaway_fault got %b want 1", oFault); end
        tests++; if (oInstr_cnt !== 16'd0) begin failed++; $display("FAIL runaway_cnt got %0d want 0", oInstr_cnt); end
        for (int i = 0; i < 3; i++) begin
            iRun = 1;
            tick();
            iRun = 0; iClear = 1; iDone = 1;
            tick();
            iClear = 0; iDone = 0;
        end
        tests++; if (oFault !== 1'b1) begin failed++; $display("FAIL runaway_sticky got %b want 1", oFault); end
        tests++; if (oInstr_cnt !== 16'd3) begin failed++; $display("FAIL runaway_good_cnt got %0d want 3", oInstr_cnt); end
        do_reset();
        tests++; if (oFault !== 1'b0) begin failed++; $display("FAIL runaway_reset got %b want 0", oFault); end
    endtask

    task automatic test_priority();
        do_reset();
        iClear = 1; iRun = 1;
        tick();
        tests++; if (oState !== 2'b00) begin failed++; $display("FAIL prio_clear_run got %b want 00", oState); end
        iClear = 0; iRun = 0; iDone = 1;
        tick();
        iDone = 0;
        tests++; if (oInstr_cnt !== 16'd0) begin failed++; $display("FAIL prio_done_t0 got %0d want 0", oInstr_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        iRun = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (oState !== 2'b01) begin failed++; $display("FAIL b2b_start[%0d] got %b want 01", i, oState); end
            iClear = 1; iDone = 1;
            tick();
            iClear = 0; iDone = 0;
            tests++;
            if (oState !== 2'b00) begin failed++; $display("FAIL b2b_end[%0d] got %b want 00", i, oState); end
        end
        iRun = 0;
        tests++; if (oInstr_cnt !== 16'd4) begin failed++; $display("FAIL b2b_cnt got %0d want 4", oInstr_cnt); end
        tests++; if (oInstr_cnt_w !== 2'd0) begin failed++; $display("FAIL cnt_wrap got %0d want 0", oInstr_cnt_w); end
    endtask

`ifdef SEQ_SINGLE_STEP_EN
    task automatic test_single_step();
        do_reset();
        iRun = 1;
        tick();
        iRun = 0; iStep = 0;
        for (int i = 0; i < 5; i++) tick();
        tests++; if (oState !== 2'b01) begin failed++; $display("FAIL step_hold got %b want 01", oState); end
        iStep = 1;
        tick();
        iStep = 0;
        tests++; if (oState !== 2'b10) begin failed++; $display("FAIL step_pulse got %b want 10", oState); end
        iClear = 1;
        tick();
        iClear = 0; iStep = 1;
        tests++; if (oState !== 2'b00) begin failed++; $display("FAIL step_clear got %b want 00", oState); end
    endtask
`endif

    initial begin
        idle_inputs();
        test_reset();
        test_two_step();
        test_four_step();
        test_runaway();
        test_priority();
        test_back_to_back();
`ifdef SEQ_SINGLE_STEP_EN
        test_single_step();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/step_sequencer.md
# step_sequencer

Step sequencer and instruction register for the 16-bit processor. It sits directly upstream of `control_unit`. It holds the current instruction step (T0–T3), drives `control_unit`'s `iState` and `ir` inputs, and reacts to `control_unit`'s `oIr_en`, `oClear` and `oDone` outputs. It also counts completed instructions and flags runaway sequences that reach T3 without being cleared.

## Interface
Parameters:
- `IR_W`, 9: instruction register width; matches `control_unit` `ir`.
- `CNT_W`, 16: completed-instruction counter width.

Ports:
- `iClk`, in, 1: clock. All state changes on the rising edge.
- `iRst`, in, 1: reset. Synchronous, active-high.
- `iRun`, in, 1: start request, sampled only in T0.
- `iDin`, in, 16: data bus. The IR is loaded from `iDin[15:7]`.
- `iIr_en`, in, 1: IR load strobe, from `control_unit` `oIr_en`.
- `iClear`, in, 1: return to T0, from `control_unit` `oClear`.
- `iDone`, in, 1: instruction complete, from `control_unit` `oDone`.
- `iStep`, in, 1: advance enable. Present only with `SEQ_SINGLE_STEP_EN`.
- `oState`, out, 2: current step, 00=T0 … 11=T3. Connects to `control_unit` `iState`.
- `oIr`, out, `IR_W`: instruction register. Connects to `control_unit` `ir`.
- `oBusy`, out, 1: high when `oState` ≠ T0.
- `oInstr_cnt`, out, `CNT_W`: completed-instruction count.
- `oFault`, out, 1: sticky runaway flag.

## Operation
- Reset (`iRst`=1 at an edge) forces `oState`=T0, `oIr`=0, `oInstr_cnt`=0 and `oFault`=0. Reset overrides every other input, including in mid-instruction.
- State transitions, in priority order:
  1. `iClear`=1 in any state: next state is T0. In T0 this suppresses a pending `iRun`.
  2. T0 with `iRun`=1: next state is T1.
  3. T0 with `iRun`=0: stay in T0.
  4. T1 → T2 and T2 → T3 unconditionally.
  5. T3 with `iClear`=0: next state is T0 and `oFault` is set to 1.
- `oFault` stays at 1 until reset. Operation continues normally while it is set.
- Deasserting `iRun` mid-instruction has no effect; the instruction runs to clear or wrap.
- IR load: `oIr` ← `iDin[15:7]` on any edge where `iIr_en`=1, independent of state. Otherwise `oIr` holds.
- Counter: `oInstr_cnt` increments by 1 on an edge where `iDone`=1 and `oState`≠T0. It wraps modulo 2^`CNT_W` (all-ones → 0). `iDone` in T0 is ignored.
- `oBusy` is decoded combinationally from the state register.

## Timing
- `oState`, `oIr`, `oInstr_cnt` and `oFault` are registered.
- `oBusy` is combinational from `oState` only; there is no path from any input to any output within a cycle.
- `control_unit` derives `iClear`/`iDone`/`iIr_en` combinationally from `oState`/`oIr`. Each takes effect at the next edge.
- `iRun` sampled at edge k (state T0) gives `oState`=T1 after edge k.
- An IR loaded at that same edge is visible together with T1.
- Instruction length in cycles:
  - 2 when cleared in T1.
  - 3 when cleared in T2.
  - 4 when cleared in T3.
  - A runaway sequence also takes 4 cycles and sets `oFault`.
- Back-to-back execution: with `iRun` held high, the cycle after a clear is T0 and the following edge starts the next instruction. There are no bubbles beyond T0.

## Configuration
- `SEQ_SINGLE_STEP_EN` defined:
  - Adds the `iStep` port.
  - Transition rules 2, 4 and 5 (including setting `oFault`) happen only on edges where `iStep`=1. With `iStep`=0 the state holds.
  - `iClear`, reset, IR load and the counter are not gated by `iStep`.
- `SEQ_SINGLE_STEP_EN` undefined: no `iStep` port, and the sequencer behaves as if `iStep`=1 permanently.

## Test plan
- Reset: hold `iRst`=1 for 2 cycles with `iRun`=1 and `iIr_en`=1 → `oState`=00, `oIr`=0, `oInstr_cnt`=0, `oFault`=0, `oBusy`=0. Apply `iRst`=1 while in T2 → T0 after the next edge.
- Two-step instruction: `iDin`=16'h2080, `iRun`=1, `iIr_en`=1 in T0 → `oIr`=9'h041, `oState`=01. Assert `iClear`=1 and `iDone`=1 in T1 → `oState`=00 and `oInstr_cnt`=1 after the next edge.
- Four-step instruction: clear and done asserted in T3 → `oState` sequence 0,1,2,3,0, `oInstr_cnt` +1, `oFault` stays 0.
- Runaway: no `iClear` through T3 → `oState` returns to 0, `oFault`=1, `oInstr_cnt` unchanged. `oFault` stays 1 across 3 further good instructions and clears only on reset.
- Priority: `iClear`=1 with `iRun`=1 in T0 → stays T0. `iDone`=1 in T0 → counter unchanged.
- With `SEQ_SINGLE_STEP_EN`: `iStep`=0 for 5 cycles in T1 → `oState` holds 01. One `iStep` pulse → 10. `iClear`=1 with `iStep`=0 → 00.
